// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-SRAM arbiter: FSM state encoding,
// default bus widths and the fetch-streak counter type.
package imem_arbiter_pkg;

    // Default widths: 1024-word instruction SRAM, 32-bit instructions.
    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DATA_W = 32;

    // The streak counter must hold MAX_FETCH_BURST values up to 255.
    localparam int STREAK_W = 8;

    typedef logic [STREAK_W-1:0] streak_t;

    // Arbiter modes. RUN is normal shared operation, DRAIN retires the last
    // fetch before exclusive access, HALTED gives the loader the SRAM, and
    // RESUME hands the first cycle back to fetch.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_RESUME = 2'd3
    } arb_state_e;

    // Saturating increment used for the consecutive-fetch counter.
    function automatic streak_t streak_inc(input streak_t cur, input streak_t lim);
        streak_t res;
        if (cur >= lim) begin
            res = lim;
        end else begin
            res = cur + streak_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch port, loader port, halt control and SRAM port around
// the instruction-memory arbiter. The arbiter uses the slave view; the
// environment (pipeline, loader and SRAM together) uses the master view.
interface imem_arbiter_if
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
);

    // IF-stage fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Debug / program-loader port
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    // Halt control and pipeline freeze
    logic              dbg_halt;
    logic              halted;
    logic              cpu_stall;

    // Single-port SRAM
    logic              sram_cs;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        input  dbg_halt,
        output halted, cpu_stall,
        output sram_cs, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        output dbg_halt,
        input  halted, cpu_stall,
        input  sram_cs, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );

endinterface

// File: rtl/imem_arbiter.sv
// Arbiter for the single-port instruction SRAM shared by the IF-stage fetch
// port and the debug/program loader. Fetch normally wins; the loader is
// guaranteed a slot after MAX_FETCH_BURST consecutive fetch grants, and can
// halt the CPU to own the SRAM exclusively. Grants are combinational; read
// valids and the halted flag are registered.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W          = IMEM_ADDR_W,
    parameter int DATA_W          = IMEM_DATA_W,
    parameter int MAX_FETCH_BURST = 8
) (
    input  logic           clk,
    input  logic           reset,
    imem_arbiter_if.slave  bus
);

    localparam streak_t STREAK_MAX = streak_t'(MAX_FETCH_BURST);

    arb_state_e state_q, state_d;
    streak_t    streak_q, streak_d;
    logic       halted_q, halted_d;
    logic       if_rvalid_q;
    logic       dbg_rvalid_q;

    logic       if_gnt;
    logic       dbg_gnt;

    // Grant decision for the current cycle; nothing is granted while reset is high.
    always_comb begin
        if_gnt  = 1'b0;
        dbg_gnt = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_RUN: begin
                    // Loader wins when fetch is idle or fetch has used up its burst.
                    dbg_gnt = bus.dbg_req & (~bus.if_req | (streak_q == STREAK_MAX));
                    if_gnt  = bus.if_req & ~dbg_gnt;
                end
                ST_DRAIN, ST_HALTED: begin
                    dbg_gnt = bus.dbg_req;
                end
                ST_RESUME: begin
                    if_gnt = bus.if_req;
                end
                default: begin
                    if_gnt  = 1'b0;
                    dbg_gnt = 1'b0;
                end
            endcase
        end
    end

    // Next mode and fetch-streak count.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        case (state_q)
            ST_RUN: begin
                if (bus.dbg_halt) begin
                    state_d = ST_DRAIN;
                end
                // The streak only measures fetches that made a waiting loader wait.
                if (!bus.dbg_req || dbg_gnt) begin
                    streak_d = '0;
                end else if (if_gnt) begin
                    streak_d = streak_inc(streak_q, STREAK_MAX);
                end
            end
            ST_DRAIN: begin
                // Exactly one cycle, even if dbg_halt has already dropped.
                state_d  = ST_HALTED;
                streak_d = '0;
            end
            ST_HALTED: begin
                if (!bus.dbg_halt) begin
                    state_d = ST_RESUME;
                end
                streak_d = '0;
            end
            ST_RESUME: begin
                state_d  = ST_RUN;
                streak_d = '0;
            end
            default: begin
                state_d  = ST_RUN;
                streak_d = '0;
            end
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    // Mode, streak, halted flag and read-return valids; reset drops in-flight reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            streak_q     <= '0;
            halted_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            halted_q     <= halted_d;
            if_rvalid_q  <= if_gnt;
            dbg_rvalid_q <= dbg_gnt & ~bus.dbg_we;
        end
    end

    // SRAM port is driven by whichever requester holds the grant.
    assign bus.sram_cs    = if_gnt | dbg_gnt;
    assign bus.sram_we    = dbg_gnt & bus.dbg_we;
    assign bus.sram_addr  = dbg_gnt ? bus.dbg_addr : bus.if_addr;
    assign bus.sram_wdata = dbg_gnt ? bus.dbg_wdata : '0;

    // Read data is steered to the port that issued last cycle's read.
    assign bus.if_gnt     = if_gnt;
    assign bus.if_rvalid  = if_rvalid_q;
    assign bus.if_rdata   = if_rvalid_q ? bus.sram_rdata : '0;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.dbg_rdata  = dbg_rvalid_q ? bus.sram_rdata : '0;

    // The pipeline freezes on a refused fetch and for the whole exclusive window.
    assign bus.halted     = halted_q;
    assign bus.cpu_stall  = reset
                          | (bus.if_req & ~if_gnt)
                          | (state_q == ST_DRAIN)
                          | (state_q == ST_HALTED);

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model of the arbitration rules.
module tb_imem_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int MAXB = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    imem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_FETCH_BURST(MAXB)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // Behavioural SRAM with one-cycle read latency and a preload port.
    logic          preload = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    logic [DW-1:0] sram_mem [0:1023];
    logic [DW-1:0] sram_q = '0;

    always @(posedge clk) begin
        if (preload) begin
            sram_mem[pl_addr] <= pl_data;
        end else if (bus.sram_cs) begin
            if (bus.sram_we) sram_mem[bus.sram_addr] <= bus.sram_wdata;
            sram_q <= sram_mem[bus.sram_addr];
        end
    end
    assign bus.sram_rdata = sram_q;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: mode (0 run, 1 drain, 2 halted, 3 resume), number of
    // fetches a waiting loader has sat through, expected read returns and an
    // image of the memory contents.
    int          ph;
    int          waited;
    bit          m_if_rv, m_dbg_rv;
    logic [31:0] m_if_data, m_dbg_data;
    logic [31:0] ref_mem [0:31];

    // Last observed DUT outputs, for scenario-specific checks.
    bit          o_if_gnt, o_dbg_gnt, o_stall, o_halted, o_dbg_rvalid;
    logic [31:0] o_if_rdata, o_dbg_rdata;

    task automatic model_reset();
        ph       = 0;
        waited   = 0;
        m_if_rv  = 1'b0;
        m_dbg_rv = 1'b0;
    endtask

    task automatic drive(input bit ir, input int ia, input bit dr, input bit dw,
                         input int da, input logic [31:0] dd, input bit dh);
        bus.if_req    = ir;
        bus.if_addr   = AW'(ia);
        bus.dbg_req   = dr;
        bus.dbg_we    = dw;
        bus.dbg_addr  = AW'(da);
        bus.dbg_wdata = dd;
        bus.dbg_halt  = dh;
    endtask

    // Called just after a falling edge with inputs applied: checks one cycle,
    // advances the model across the rising edge, returns at the next falling edge.
    task automatic step();
        bit e_if, e_dbg, e_stall;
        int ia, da;
        #1;
        ia = int'(bus.if_addr[4:0]);
        da = int'(bus.dbg_addr[4:0]);
        e_if  = 1'b0;
        e_dbg = 1'b0;
        if (ph == 0) begin
            e_dbg = bus.dbg_req && (!bus.if_req || waited >= MAXB);
            e_if  = bus.if_req && !e_dbg;
        end else if (ph == 1 || ph == 2) begin
            e_dbg = bus.dbg_req;
        end else begin
            e_if = bus.if_req;
        end
        e_stall = (bus.if_req && !e_if) || ph == 1 || ph == 2;

        o_if_gnt     = bus.if_gnt;
        o_dbg_gnt    = bus.dbg_gnt;
        o_stall      = bus.cpu_stall;
        o_halted     = bus.halted;
        o_dbg_rvalid = bus.dbg_rvalid;
        o_if_rdata   = bus.if_rdata;
        o_dbg_rdata  = bus.dbg_rdata;

        check_val("if_gnt", bus.if_gnt, e_if);
        check_val("dbg_gnt", bus.dbg_gnt, e_dbg);
        check_val("sram_cs", bus.sram_cs, e_if | e_dbg);
        check_val("sram_we", bus.sram_we, e_dbg & bus.dbg_we);
        if (e_dbg) check_val("sram_addr_dbg", bus.sram_addr, bus.dbg_addr);
        if (e_if) check_val("sram_addr_if", bus.sram_addr, bus.if_addr);
        if (e_dbg && bus.dbg_we) check_val("sram_wdata", bus.sram_wdata, bus.dbg_wdata);
        check_val("cpu_stall", bus.cpu_stall, e_stall);
        check_val("halted", bus.halted, ph == 2);
        check_val("if_rvalid", bus.if_rvalid, m_if_rv);
        check_val("dbg_rvalid", bus.dbg_rvalid, m_dbg_rv);
        check_val("if_rdata", bus.if_rdata, m_if_rv ? m_if_data : 32'h0);
        check_val("dbg_rdata", bus.dbg_rdata, m_dbg_rv ? m_dbg_data : 32'h0);

        @(posedge clk);
        if (e_if) m_if_data = ref_mem[ia];
        m_if_rv = e_if;
        if (e_dbg && !bus.dbg_we) m_dbg_data = ref_mem[da];
        m_dbg_rv = e_dbg && !bus.dbg_we;
        if (e_dbg && bus.dbg_we) ref_mem[da] = bus.dbg_wdata;

        if (ph == 0) begin
            if (!bus.dbg_req || e_dbg) waited = 0;
            else if (e_if && waited < MAXB) waited++;
            ph = bus.dbg_halt ? 1 : 0;
        end else begin
            waited = 0;
            if (ph == 1) ph = 2;
            else if (ph == 2) ph = bus.dbg_halt ? 2 : 3;
            else ph = 0;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse applied mid-cycle; outputs must drop at once.
    task automatic do_reset_check(input string tag);
        reset = 1'b1;
        #1;
        check_val({tag, "_if_gnt"}, bus.if_gnt, 1'b0);
        check_val({tag, "_dbg_gnt"}, bus.dbg_gnt, 1'b0);
        check_val({tag, "_cs"}, bus.sram_cs, 1'b0);
        check_val({tag, "_we"}, bus.sram_we, 1'b0);
        check_val({tag, "_stall"}, bus.cpu_stall, 1'b1);
        check_val({tag, "_if_rvalid"}, bus.if_rvalid, 1'b0);
        check_val({tag, "_dbg_rvalid"}, bus.dbg_rvalid, 1'b0);
        check_val({tag, "_halted"}, bus.halted, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int  nfetch;
        bit  got;
        bit  dh_r;
        logic [31:0] v;

        reset = 1'b1;
        drive(1, 0, 1, 1, 0, 32'hFFFF_FFFF, 1);
        model_reset();

        // Preload the low 32 words while reset holds the arbiter idle.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            case (i)
                0: v = 32'h0010_0093;
                1: v = 32'h0020_0113;
                2: v = 32'h0030_0193;
                default: v = $urandom;
            endcase
            preload = 1'b1;
            pl_addr = AW'(i);
            pl_data = v;
            ref_mem[i] = v;
        end
        @(negedge clk);
        preload = 1'b0;
        do_reset_check("rst");

        // Both ports request on the first cycle out of reset: fetch wins.
        drive(1, 0, 1, 0, 3, 0, 0);
        step();
        check_val("rel_if_gnt", o_if_gnt, 1'b1);
        check_val("rel_dbg_gnt", o_dbg_gnt, 1'b0);

        // Fetch-only stream over addresses 0..2.
        for (int i = 0; i < 3; i++) begin
            drive(1, i, 0, 0, 0, 0, 0);
            step();
            check_val("fetch_stall", o_stall, 1'b0);
            if (i == 2) check_val("fetch_data1", o_if_rdata, 32'h0020_0113);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        check_val("fetch_data2", o_if_rdata, 32'h0030_0193);

        // Loader write with fetch idle, then fetch of the same word.
        drive(0, 0, 1, 1, 5, 32'hDEAD_BEEF, 0);
        step();
        check_val("dbgw_gnt", o_dbg_gnt, 1'b1);
        drive(1, 5, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        check_val("dbgw_fetch", o_if_rdata, 32'hDEAD_BEEF);

        // Starvation guard: continuous fetch with a waiting loader read.
        nfetch = 0;
        got    = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            drive(1, 10 + c, 1, 0, 3, 0, 0);
            step();
            if (o_dbg_gnt) begin
                got = 1'b1;
                check_val("starve_stall", o_stall, 1'b1);
                check_val("starve_if_gnt", o_if_gnt, 1'b0);
            end else if (o_if_gnt) begin
                nfetch++;
            end
        end
        check_val("starve_fetches", nfetch, MAXB);
        check_val("starve_dbg_gnt", got, 1'b1);
        drive(1, 31, 0, 0, 0, 0, 0);
        step();
        check_val("starve_rvalid", o_dbg_rvalid, 1'b1);
        check_val("starve_rdata", o_dbg_rdata, ref_mem[3]);
        check_val("starve_resume", o_if_gnt, 1'b1);

        // Halt, load words 0..3, resume.
        drive(1, 4, 0, 0, 0, 0, 1);
        step();
        drive(1, 5, 0, 0, 0, 0, 1);
        step();
        check_val("drain_stall", o_stall, 1'b1);
        check_val("drain_if_gnt", o_if_gnt, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 5, 1, 1, i, 32'hA5A5_0000 + i, 1);
            step();
            check_val("halt_halted", o_halted, 1'b1);
            check_val("halt_stall", o_stall, 1'b1);
            check_val("halt_dbg_gnt", o_dbg_gnt, 1'b1);
        end
        drive(1, 6, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        check_val("resume_if_gnt", o_if_gnt, 1'b1);
        check_val("resume_stall", o_stall, 1'b0);
        check_val("resume_halted", o_halted, 1'b0);
        drive(1, 1, 0, 0, 0, 0, 0);
        step();
        check_val("resume_data0", o_if_rdata, 32'hA5A5_0000);

        // Reset in the cycle after a fetch grant drops the returning read.
        drive(1, 7, 0, 0, 0, 0, 0);
        step();
        check_val("prerst_rvalid", bus.if_rvalid, 1'b1);
        do_reset_check("rst_mid");
        drive(1, 8, 1, 0, 9, 0, 0);
        step();
        check_val("rst_mid_after", o_if_gnt, 1'b1);

        // Halt then reset while HALTED: back to shared operation.
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        step();
        step();
        do_reset_check("rst_halt");
        drive(1, 2, 0, 0, 0, 0, 0);
        step();
        check_val("rst_halt_run", o_stall, 1'b0);

        // Random traffic with occasional halts and reset pulses.
        dh_r = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 15) == 0) dh_r = !dh_r;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 31),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 31), $urandom, dh_r);
            step();
            if ($urandom_range(0, 199) == 0) do_reset_check("rst_rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
